ds_lsu: RTL
===========

Name: ds_lsu

Overview:
- Load/store initiator that drives the byte/half/word data store from the CPU datapath side.
- Accepts one memory request per handshake, checks alignment, and drives the store's str/mode/address/data_in port.
- On loads, captures the right-aligned, zero-filled store output and sign- or zero-extends it.
- Returns a response with error status and keeps a saturating count of faulting requests.

Parameters:
- AWIDTH, 12: byte-address width (4 KiB store).
- DWIDTH, 32: data word width. Only 32 is supported.

Ports:
- clk  input  1  clock; all state updates on posedge.
- clr  input  1  reset, asynchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 word, 01 byte, 10 half, 11 illegal. Same encoding as the store's mode.
- req_signed  input  1  sign-extend byte/half loads. Ignored for word loads and for stores.
- req_addr  input  AWIDTH  byte address.
- req_wdata  input  DWIDTH  store data, right-aligned.
- resp_valid  output  1  one-cycle response pulse.
- resp_err  output  1  qualifies resp_valid: misaligned or illegal request.
- resp_rdata  output  DWIDTH  load result; 0 for stores and errors.
- err_cnt  output  8  saturating count of error responses.
- ds_str  output  1  store write strobe.
- ds_mode  output  2  store access mode.
- ds_addr  output  AWIDTH  store byte address.
- ds_din  output  DWIDTH  store write data, right-aligned. The store performs lane shifting.
- ds_dout  input  DWIDTH  store read data: combinational, right-aligned, upper bits zero.

Behaviour:
- States: IDLE, READ, WRITE, RESP, ERR. State register resets asynchronously to IDLE.
- Reset values: resp_valid 0, resp_err 0, resp_rdata 0, err_cnt 0, ds_str 0, ds_mode 00, ds_addr 0, ds_din 0. req_ready is 0 while clr is high.
- req_ready = (state == IDLE) && !clr.
- IDLE: a handshake (req_valid && req_ready) latches we/size/signed/addr/wdata. Next state:
  - ERR if size==11, or size==10 with addr[0]==1, or size==00 with addr[1:0]!=0;
  - otherwise WRITE if we, else READ.
- ds_addr and ds_mode come from the latched registers and hold between requests.
- ds_din = latched wdata masked to the size: byte keeps [7:0], half keeps [15:0], upper bits 0.
- READ:
  - ds_str = 0.
  - At the clock edge, capture ds_dout into resp_rdata.
  - Byte: signed gives {24{d[7]},d[7:0]}, unsigned gives {24'b0,d[7:0]}.
  - Half: signed gives {16{d[15]},d[15:0]}, unsigned gives zero-extended.
  - Word: d unchanged.
  - Next state RESP.
- WRITE: ds_str = 1 for exactly this one cycle, decoded combinationally from the state register. resp_rdata is set to 0. Next state RESP.
- RESP: resp_valid 1, resp_err 0 for one cycle, then IDLE.
- ERR:
  - resp_valid 1, resp_err 1, resp_rdata 0 for one cycle, then IDLE.
  - ds_str never asserts for a faulting request.
  - err_cnt increments on entry to ERR and saturates at 255.
- Timing:
  - Handshake in cycle N: READ/WRITE/ERR occupies cycle N+1; resp_valid is high in cycle N+2 for RESP and in N+1 for ERR.
  - Next accept is possible in N+3 (success) or N+2 (error).
- req_valid while req_ready is 0 is not accepted, and the request inputs are not sampled. The requester must hold the request.
- resp_rdata holds its value until the next READ/WRITE/ERR; only resp_valid pulses.
- clr mid-operation:
  - State returns to IDLE immediately.
  - ds_str drops asynchronously in the same cycle.
  - No response is produced for the aborted request.
  - All registered outputs and err_cnt are cleared.
- Address wrap: none; every address is within the 2^AWIDTH store.

Test Plan:
1. Hold clr high for 3 cycles, then release -> all outputs 0, req_ready 0 during clr, req_ready 1 in the first cycle after release.
2. Store word 0xDEADBEEF at 0x010 -> ds_str high exactly one cycle with ds_mode 00 and ds_addr 0x010; resp_valid at N+2 with resp_err 0. Then load word 0x010 -> resp_rdata 0xDEADBEEF.
3. Load byte at 0x013: signed -> 0xFFFFFFDE, unsigned -> 0x000000DE. Load half at 0x012: signed -> 0xFFFFDEAD. Load half at 0x010: unsigned -> 0x0000BEEF.
4. Load word at 0x011, half at 0x013, size 11 at 0x000 -> no ds_str, resp_valid at N+1 with resp_err 1, resp_rdata 0, err_cnt = 3. Issue 300 faulting requests -> err_cnt stays at 255.
5. Keep req_valid high for three back-to-back stores -> accepts in cycles N, N+3, N+6; exactly one ds_str pulse per store.
6. Assert clr during a WRITE cycle -> ds_str falls in the same cycle, no resp_valid, the target word is unchanged, and req_ready is 1 after clr is released.

Source files
------------

// File: rtl/ds_lsu_if.sv
// Request/response channel between the CPU datapath and the load/store unit.
// The master side issues memory requests; the slave side (ds_lsu) answers them.
interface ds_lsu_if #(
    parameter int AWIDTH = 12,
    parameter int DWIDTH = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [AWIDTH-1:0] req_addr;
    logic [DWIDTH-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [DWIDTH-1:0] resp_rdata;

    modport master (
        output req_valid,
        output req_we,
        output req_size,
        output req_signed,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  resp_valid,
        input  resp_err,
        input  resp_rdata
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_size,
        input  req_signed,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output resp_valid,
        output resp_err,
        output resp_rdata
    );
endinterface

// File: rtl/ds_lsu.sv
// Load/store initiator for the byte/half/word data store: alignment check,
// store port drive, load extension and a saturating fault counter.
module ds_lsu #(
    parameter int AWIDTH = 12,
    parameter int DWIDTH = 32   // only 32 is supported
) (
    input  logic              clk,
    input  logic              clr,
    ds_lsu_if.slave           bus,
    output logic [7:0]        err_cnt,
    output logic              ds_str,
    output logic [1:0]        ds_mode,
    output logic [AWIDTH-1:0] ds_addr,
    output logic [DWIDTH-1:0] ds_din,
    input  logic [DWIDTH-1:0] ds_dout
);
    // state | meaning
    // IDLE  | waiting for a request, req_ready high
    // READ  | store read port presents data, captured at the edge
    // WRITE | ds_str asserted for this single cycle
    // RESP  | successful response pulse
    // ERR   | error response pulse for a misaligned/illegal request
    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        RESP,
        ERR
    } state_t;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;

    state_t            state;
    state_t            state_nxt;
    logic              ready;
    logic              accept;
    logic              fault;
    logic              str;
    logic              rsp_valid;
    logic              rsp_err;
    logic [1:0]        size_q;
    logic              sgn_q;
    logic [AWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] wdata_q;
    logic [DWIDTH-1:0] rdata_q;
    logic [DWIDTH-1:0] load_ext;
    logic [DWIDTH-1:0] din_masked;

    assign ready  = (state == IDLE) && !clr;
    assign accept = bus.req_valid && ready;

    always_comb begin
        fault = 1'b0;
        case (bus.req_size)
            SZ_WORD: fault = (bus.req_addr[1:0] != 2'b00);
            SZ_HALF: fault = bus.req_addr[0];
            SZ_BYTE: fault = 1'b0;
            default: fault = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        str       = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (fault) begin
                        state_nxt = ERR;
                    end else if (bus.req_we) begin
                        state_nxt = WRITE;
                    end else begin
                        state_nxt = READ;
                    end
                end
            end
            READ: begin
                state_nxt = RESP;
            end
            WRITE: begin
                str       = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_nxt = IDLE;
            end
            ERR: begin
                rsp_valid = 1'b1;
                rsp_err   = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request fields are only sampled on a handshake; they drive the store between requests.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            size_q  <= SZ_WORD;
            sgn_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            size_q  <= bus.req_size;
            sgn_q   <= bus.req_signed;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
        end
    end

    always_comb begin
        case (size_q)
            SZ_BYTE: load_ext = sgn_q ? {{(DWIDTH-8){ds_dout[7]}}, ds_dout[7:0]}
                                      : {{(DWIDTH-8){1'b0}}, ds_dout[7:0]};
            SZ_HALF: load_ext = sgn_q ? {{(DWIDTH-16){ds_dout[15]}}, ds_dout[15:0]}
                                      : {{(DWIDTH-16){1'b0}}, ds_dout[15:0]};
            default: load_ext = ds_dout;
        endcase
    end

    always_comb begin
        case (size_q)
            SZ_BYTE: din_masked = {{(DWIDTH-8){1'b0}}, wdata_q[7:0]};
            SZ_HALF: din_masked = {{(DWIDTH-16){1'b0}}, wdata_q[15:0]};
            default: din_masked = wdata_q;
        endcase
    end

    // Fault result is cleared at the accepting edge so it is already 0 during the ERR pulse.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rdata_q <= '0;
            err_cnt <= 8'd0;
        end else begin
            if (accept && fault) begin
                rdata_q <= '0;
                if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end
            if (state == READ) begin
                rdata_q <= load_ext;
            end
            if (state == WRITE) begin
                rdata_q <= '0;
            end
        end
    end

    assign bus.req_ready  = ready;
    assign bus.resp_valid = rsp_valid;
    assign bus.resp_err   = rsp_err;
    assign bus.resp_rdata = rdata_q;

    assign ds_str  = str;
    assign ds_mode = size_q;
    assign ds_addr = addr_q;
    assign ds_din  = din_masked;
endmodule
